hv_resp_receiver: RTL and testbench
===================================

HV_RESP_RECEIVER -- requirements
Module: hv_resp_receiver

Interface
REQ-001 SHALL have parameter CLK_RATE, default 40000000, meaning clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 38400, meaning UART bit rate.
REQ-003 SHALL have parameter MAX_LEN, default 32, meaning maximum payload bytes between STX and CR.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 40, meaning the inter-byte idle limit in bit periods.
REQ-005 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 SHALL have port line  input  1  serial input from HV supply, idle high, asynchronous to clk.
REQ-008 SHALL have port err_clr  input  1  synchronous pulse that releases the ERR state.
REQ-009 SHALL have port dout  output  8  last accepted payload byte.
REQ-010 SHALL have port valid  output  1  one-cycle strobe, dout holds a new payload byte.
REQ-011 SHALL have port frame_done  output  1  one-cycle strobe at CR of a well-formed frame.
REQ-012 SHALL have port frame_len  output  6  payload byte count, valid while frame_done=1.
REQ-013 SHALL have port err_code  output  2  00 none, 01 framing, 10 overflow, 11 timeout.
REQ-014 SHALL have port busy  output  1  high from STX acceptance until frame_done or error.

Function
REQ-015 SHALL pass line through a 2-flop synchronizer before any use (2-cycle input latency).
REQ-016 SHALL compute bit period BIT_CNT = CLK_RATE/BAUD_RATE (integer division; 1041 at defaults).
REQ-017 Byte RX SHALL detect the start on a synchronized falling edge, re-sample at BIT_CNT/2, and abort silently to idle if the sample is high (glitch).
REQ-018 Byte RX SHALL sample 8 data bits LSB first, each BIT_CNT after the previous sample, then sample the stop bit.
REQ-019 A stop bit sampled low SHALL raise a framing error; the byte SHALL be discarded.
REQ-020 The frame FSM SHALL have states IDLE, PAYLOAD, ERR; the encoding is one-hot.
REQ-021 IDLE: bytes other than 0x02 SHALL be ignored; 0x02 SHALL clear the count and go to PAYLOAD.
REQ-022 PAYLOAD: 0x0D SHALL pulse frame_done with frame_len=count and return to IDLE.
REQ-023 PAYLOAD: 0x02 SHALL restart the frame (count=0) without an error.
REQ-024 PAYLOAD: any other byte SHALL drive dout, pulse valid one cycle after the stop-bit sample, and increment count.
REQ-025 A data byte arriving when count==MAX_LEN SHALL go to ERR with err_code=10 and SHALL NOT pulse valid.
REQ-026 A framing error in PAYLOAD SHALL go to ERR with err_code=01; in IDLE it SHALL be ignored.
REQ-027 ERR SHALL hold err_code and ignore line until err_clr; err_clr SHALL go to IDLE with err_code=00.
REQ-028 busy SHALL be 1 exactly while the FSM is in PAYLOAD.
REQ-029 valid and frame_done SHALL never be high in the same cycle.

Reset
REQ-030 rst_n low SHALL force IDLE, dout=0, valid=0, frame_done=0, frame_len=0, err_code=00, busy=0, synchronizer flops=1, all counters=0.
REQ-031 Reset mid-byte or mid-frame SHALL discard partial data; after release, reception SHALL resume only on a new falling edge.

Configuration
REQ-032 With HV_RX_TIMEOUT_EN defined, an idle line for TIMEOUT_BITS*BIT_CNT cycles in PAYLOAD (counted from the last stop-bit sample or STX) SHALL go to ERR with err_code=11.
REQ-033 Without HV_RX_TIMEOUT_EN, no timeout counter SHALL exist, code 11 SHALL never occur, and PAYLOAD SHALL wait indefinitely.

Structure
REQ-034 Package hv_uart_pkg SHALL hold the STX (8'h02) and CR (8'h0D) constants, the FSM state encodings, and the err_code values.
REQ-035 Bit-level deserialization SHALL be the sub-module hv_uart_byte_rx (outputs: byte, byte_strobe, frame_err); hv_resp_receiver SHALL hold the synchronizer-independent frame FSM.

Verification
REQ-036 Send bytes 02 41 42 0D at 38400 baud -> valid strobes with dout 41 then 42; frame_done=1 with frame_len=2; err_code=00.
REQ-037 Send 02 then 41 with the stop bit driven low -> err_code=01, busy=0, no valid; err_clr pulse -> err_code=00, IDLE.
REQ-038 Send 02 then 33 bytes of 55 -> 32 valid strobes, then err_code=10 and no 33rd valid.
REQ-039 Drive a 10-cycle low glitch on idle line -> no byte, no state change.
REQ-040 Macro on: send 02 41, then hold line high for 40*1041 cycles -> err_code=11. Macro off: same stimulus -> busy stays 1.
REQ-041 Assert rst_n low mid-byte of 02 41 -> all outputs are reset values; subsequent 02 43 0D -> frame_len=1, dout=43.

Source files
------------

// File: rtl/hv_uart_pkg.sv
// Shared constants and encodings for the HV supply response receiver.
// Holds the frame delimiters, the one-hot frame FSM encoding, the
// byte-receiver FSM encoding and the err_code values.
package hv_uart_pkg;

   localparam logic [7:0] STX = 8'h02;
   localparam logic [7:0] CR  = 8'h0D;

   // Frame FSM, one-hot
   typedef enum logic [2:0] {
      ST_IDLE    = 3'b001,
      ST_PAYLOAD = 3'b010,
      ST_ERR     = 3'b100
   } frame_state_t;

   // err_code output values
   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_FRAMING  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

   // Bit-level receiver FSM
   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/hv_uart_byte_rx.sv
// UART byte deserializer (8N1, LSB first) for the HV supply line.
// Ports:
//   clk, rst_n   - clock, async active-low reset
//   line         - raw serial input, idle high, asynchronous to clk
//   rx_byte      - last byte received with a good stop bit
//   byte_strobe  - one-cycle pulse, rx_byte just updated
//   frame_err    - one-cycle pulse, stop bit sampled low (byte dropped)
module hv_uart_byte_rx
   import hv_uart_pkg::*;
#(
   parameter int unsigned BIT_CNT = 1041
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line,
   output logic [7:0] rx_byte,
   output logic       byte_strobe,
   output logic       frame_err
);

   localparam int unsigned CNT_W = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_CNT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(BIT_CNT - 1);

   logic             line_meta;
   logic             line_sync;
   logic             line_prev;
   logic             fall_c;
   logic             tick_c;

   rx_state_t        state;
   rx_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [2:0]       bit_idx;
   logic [2:0]       bit_idx_nxt;
   logic [7:0]       shift;
   logic [7:0]       shift_nxt;
   logic [7:0]       rx_byte_nxt;
   logic             strobe_nxt;
   logic             ferr_nxt;

   // Two-flop synchronizer plus one delay flop for edge detection; all reset
   // to the idle level so reset release cannot fake a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_meta <= 1'b1;
         line_sync <= 1'b1;
         line_prev <= 1'b1;
      end else begin
         line_meta <= line;
         line_sync <= line_meta;
         line_prev <= line_sync;
      end
   end

   assign fall_c = line_prev & ~line_sync;
   // Start bit is checked half a bit in; data and stop bits one full bit apart
   assign tick_c = (state == RX_START) ? (cnt == HALF_M1) : (cnt == FULL_M1);

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RX_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         rx_byte     <= '0;
         byte_strobe <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_idx     <= bit_idx_nxt;
         shift       <= shift_nxt;
         rx_byte     <= rx_byte_nxt;
         byte_strobe <= strobe_nxt;
         frame_err   <= ferr_nxt;
      end
   end

   // Next-state logic; a high start sample is a glitch and aborts silently
   always_comb begin
      state_nxt = state;
      case (state)
         RX_IDLE:  if (fall_c) state_nxt = RX_START;
         RX_START: if (tick_c) state_nxt = line_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (tick_c && (bit_idx == 3'd7)) state_nxt = RX_STOP;
         RX_STOP:  if (tick_c) state_nxt = RX_IDLE;
         default:  state_nxt = RX_IDLE;
      endcase
   end

   // Bit timing, shift register and output strobes
   always_comb begin
      cnt_nxt     = cnt + 1'b1;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      rx_byte_nxt = rx_byte;
      strobe_nxt  = 1'b0;
      ferr_nxt    = 1'b0;
      if ((state == RX_IDLE) || tick_c) cnt_nxt = '0;
      case (state)
         RX_IDLE: bit_idx_nxt = '0;
         RX_DATA: begin
            if (tick_c) begin
               shift_nxt   = {line_sync, shift[7:1]};
               bit_idx_nxt = bit_idx + 3'd1;
            end
         end
         RX_STOP: begin
            if (tick_c) begin
               if (line_sync) begin
                  strobe_nxt  = 1'b1;
                  rx_byte_nxt = shift;
               end else begin
                  ferr_nxt = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/hv_resp_receiver.sv
// HV supply response receiver: deserializes the line and parses
// STX <payload> CR frames, reporting payload bytes, frame completion and errors.
// Optional feature: define HV_RX_TIMEOUT_EN to enable the inter-byte timeout
// (err_code 11); without it PAYLOAD waits indefinitely.
// Ports:
//   clk, rst_n  - clock, async active-low reset
//   line        - serial input, idle high, asynchronous
//   err_clr     - pulse that leaves the ERR state
//   dout/valid  - last accepted payload byte / one-cycle strobe
//   frame_done  - one-cycle strobe at CR, frame_len holds the payload count
//   err_code    - 00 none, 01 framing, 10 overflow, 11 timeout
//   busy        - high while a frame is open (PAYLOAD)
module hv_resp_receiver
   import hv_uart_pkg::*;
#(
   parameter int unsigned CLK_RATE     = 40000000,
   parameter int unsigned BAUD_RATE    = 38400,
   parameter int unsigned MAX_LEN      = 32,
   parameter int unsigned TIMEOUT_BITS = 40
)
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       line,
   input  logic       err_clr,
   output logic [7:0] dout,
   output logic       valid,
   output logic       frame_done,
   output logic [5:0] frame_len,
   output logic [1:0] err_code,
   output logic       busy
);

   localparam int unsigned BIT_CNT = CLK_RATE / BAUD_RATE;
   localparam int unsigned LEN_W   = 6;
   localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

   // Elaboration-time guard on parameters the datapath cannot represent
   if ((BIT_CNT < 2) || (MAX_LEN > 63) || (TIMEOUT_BITS == 0)) begin : g_param_err
      $error("hv_resp_receiver: unsupported parameter set");
   end

   logic [7:0]       rx_byte;
   logic             byte_strobe;
   logic             frame_err;
   logic             timeout_c;
   logic             full_c;

   frame_state_t     state;
   frame_state_t     state_nxt;
   logic [LEN_W-1:0] count;
   logic [LEN_W-1:0] count_nxt;
   logic [7:0]       dout_nxt;
   logic             valid_nxt;
   logic             done_nxt;
   logic [LEN_W-1:0] len_nxt;
   logic [1:0]       err_nxt;
   logic             busy_nxt;

   hv_uart_byte_rx #(
      .BIT_CNT (BIT_CNT)
   ) u_byte_rx (
      .clk         (clk),
      .rst_n       (rst_n),
      .line        (line),
      .rx_byte     (rx_byte),
      .byte_strobe (byte_strobe),
      .frame_err   (frame_err)
   );

   assign full_c = (count == MAX_CNT);

`ifdef HV_RX_TIMEOUT_EN
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * BIT_CNT;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT);

   logic [TO_W-1:0] to_cnt;

   // Idle counter restarts at STX acceptance and at every stop-bit sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         to_cnt <= '0;
      end else if ((state != ST_PAYLOAD) || byte_strobe || frame_err) begin
         to_cnt <= '0;
      end else if (!timeout_c) begin
         to_cnt <= to_cnt + 1'b1;
      end
   end

   assign timeout_c = (state == ST_PAYLOAD) && (to_cnt == TO_W'(TO_LIMIT - 1));
`else
   assign timeout_c = 1'b0;
`endif

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         count      <= '0;
         dout       <= '0;
         valid      <= 1'b0;
         frame_done <= 1'b0;
         frame_len  <= '0;
         err_code   <= ERR_NONE;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         dout       <= dout_nxt;
         valid      <= valid_nxt;
         frame_done <= done_nxt;
         frame_len  <= len_nxt;
         err_code   <= err_nxt;
         busy       <= busy_nxt;
      end
   end

   // Next-state logic; framing error outranks byte handling, timeout is last
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (byte_strobe && (rx_byte == STX)) state_nxt = ST_PAYLOAD;
         end
         ST_PAYLOAD: begin
            if (frame_err) begin
               state_nxt = ST_ERR;
            end else if (byte_strobe) begin
               if (rx_byte == CR) begin
                  state_nxt = ST_IDLE;
               end else if ((rx_byte != STX) && full_c) begin
                  state_nxt = ST_ERR;
               end
            end else if (timeout_c) begin
               state_nxt = ST_ERR;
            end
         end
         ST_ERR: begin
            if (err_clr) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output and payload-count logic
   always_comb begin
      count_nxt = count;
      dout_nxt  = dout;
      valid_nxt = 1'b0;
      done_nxt  = 1'b0;
      len_nxt   = frame_len;
      err_nxt   = err_code;
      case (state)
         ST_IDLE: begin
            if (byte_strobe && (rx_byte == STX)) count_nxt = '0;
         end
         ST_PAYLOAD: begin
            if (frame_err) begin
               err_nxt = ERR_FRAMING;
            end else if (byte_strobe) begin
               if (rx_byte == CR) begin
                  done_nxt = 1'b1;
                  len_nxt  = count;
               end else if (rx_byte == STX) begin
                  count_nxt = '0;
               end else if (full_c) begin
                  err_nxt = ERR_OVERFLOW;
               end else begin
                  dout_nxt  = rx_byte;
                  valid_nxt = 1'b1;
                  count_nxt = count + 6'd1;
               end
            end else if (timeout_c) begin
               err_nxt = ERR_TIMEOUT;
            end
         end
         ST_ERR: begin
            if (err_clr) err_nxt = ERR_NONE;
         end
         default: ;
      endcase
      busy_nxt = (state_nxt == ST_PAYLOAD);
   end

endmodule

// File: tb/tb_hv_resp_receiver.sv
// Self-checking bench for hv_resp_receiver. A frame-level model predicts every
// observable event (valid, frame_done, err_code change, busy change) with a
// time window; a monitor matches DUT events against that list each cycle.
`timescale 1ns/1ps
module tb_hv_resp_receiver;

   localparam int unsigned CLK_RATE = 3200000;
   localparam int unsigned BAUD     = 100000;
   localparam int unsigned BIT      = CLK_RATE / BAUD;
   localparam int unsigned MAX_LEN  = 32;
   localparam int unsigned TO_BITS  = 40;
   localparam int unsigned TO_LIMIT = TO_BITS * BIT;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       line = 1'b1;
   logic       err_clr = 1'b0;
   logic [7:0] dout;
   logic       valid;
   logic       frame_done;
   logic [5:0] frame_len;
   logic [1:0] err_code;
   logic       busy;

   hv_resp_receiver #(
      .CLK_RATE     (CLK_RATE),
      .BAUD_RATE    (BAUD),
      .MAX_LEN      (MAX_LEN),
      .TIMEOUT_BITS (TO_BITS)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .line       (line),
      .err_clr    (err_clr),
      .dout       (dout),
      .valid      (valid),
      .frame_done (frame_done),
      .frame_len  (frame_len),
      .err_code   (err_code),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endfunction

   // ---------------- expected-event model ----------------
   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         fd;
      logic [5:0] len;
      logic [1:0] err;
      bit         bsy;
      int         tmin;
      int         tmax;
   } ev_t;

   ev_t exp_q[$];
   int  m_st   = 0;    // 0 idle, 1 payload, 2 error
   int  m_cnt  = 0;
   int  m_last = 0;

   function automatic void push(input bit v, input logic [7:0] d, input bit fd,
                                input logic [5:0] len, input logic [1:0] err,
                                input bit bsy, input int tmin, input int tmax);
      ev_t e;
      e.v = v; e.d = d; e.fd = fd; e.len = len; e.err = err; e.bsy = bsy;
      e.tmin = tmin; e.tmax = tmax;
      exp_q.push_back(e);
   endfunction

   // Frame rules applied to one byte whose start bit is driven at cycle t0
   function automatic void model_byte(input logic [7:0] b, input bit ok, input int t0);
      int ts;
      int te;
      ts = t0 + 9 * BIT + BIT / 2;
      te = t0 + 10 * BIT;
      if (m_st == 2) return;
      if (!ok) begin
         if (m_st == 1) begin
            push(0, 8'h00, 0, 6'd0, 2'b01, 0, ts, te);
            m_st = 2;
         end
         return;
      end
      if (m_st == 0) begin
         if (b == 8'h02) begin
            m_st = 1; m_cnt = 0; m_last = ts;
            push(0, 8'h00, 0, 6'd0, 2'b00, 1, ts, te);
         end
         return;
      end
      m_last = ts;
      if (b == 8'h0D) begin
         push(0, 8'h00, 1, 6'(m_cnt), 2'b00, 0, ts, te);
         m_st = 0;
      end else if (b == 8'h02) begin
         m_cnt = 0;
      end else if (m_cnt == MAX_LEN) begin
         push(0, 8'h00, 0, 6'd0, 2'b10, 0, ts, te);
         m_st = 2;
      end else begin
         push(1, b, 0, 6'd0, 2'b00, 1, ts, te);
         m_cnt++;
      end
   endfunction

   // ---------------- monitor ----------------
   logic       pv_busy = 1'b0;
   logic [1:0] pv_err  = 2'b00;
   int         n_valid  = 0;
   int         n_events = 0;
   logic [7:0] last_dout = 8'h00;
   logic [5:0] last_len  = 6'd0;
   ev_t        cur;
   int         tclamp;

   always @(negedge clk) begin
      if (!rst_n) begin
         pv_busy = 1'b0;
         pv_err  = 2'b00;
      end else begin
         if (valid || frame_done) check("strobe_exclusive", 32'(valid & frame_done), 32'd0);
         if (valid || frame_done || (busy != pv_busy) || (err_code != pv_err)) begin
            n_events++;
            if (valid) begin
               n_valid++;
               last_dout = dout;
            end
            if (frame_done) last_len = frame_len;
            if (exp_q.size() == 0) begin
               check("spurious_event", {valid, frame_done, busy, err_code},
                     {1'b0, 1'b0, pv_busy, pv_err});
            end else begin
               cur = exp_q.pop_front();
               check("ev_valid", 32'(valid), 32'(cur.v));
               if (cur.v) check("ev_dout", 32'(dout), 32'(cur.d));
               check("ev_done", 32'(frame_done), 32'(cur.fd));
               if (cur.fd) check("ev_len", 32'(frame_len), 32'(cur.len));
               check("ev_err", 32'(err_code), 32'(cur.err));
               check("ev_busy", 32'(busy), 32'(cur.bsy));
               tclamp = (cyc < cur.tmin) ? cur.tmin : ((cyc > cur.tmax) ? cur.tmax : cyc);
               check("ev_time", 32'(cyc), 32'(tclamp));
            end
         end
         pv_busy = busy;
         pv_err  = err_code;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick(input int n);
      if (n <= 0) return;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      model_byte(b, ok, cyc);
      line = 1'b0;
      tick(BIT);
      for (int i = 0; i < 8; i++) begin
         line = b[i];
         tick(BIT);
      end
      line = ok;
      tick(BIT);
      line = 1'b1;
      if (!ok) tick(BIT);
   endtask

   task automatic idle_bits(input int n);
`ifdef HV_RX_TIMEOUT_EN
      if ((m_st == 1) && (cyc + n * BIT > m_last + TO_LIMIT + BIT)) begin
         push(0, 8'h00, 0, 6'd0, 2'b11, 0, m_last + TO_LIMIT - BIT, m_last + TO_LIMIT + BIT);
         m_st = 2;
      end
`endif
      tick(n * BIT);
   endtask

   task automatic pulse_clr();
      if (m_st == 2) begin
         push(0, 8'h00, 0, 6'd0, 2'b00, 0, cyc, cyc + 3);
         m_st = 0;
      end
      err_clr = 1'b1;
      tick(1);
      err_clr = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 2 * BIT)) begin
         tick(1);
         n++;
      end
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   task automatic check_reset(input string name);
      check({name, "_dout"}, 32'(dout), 32'd0);
      check({name, "_valid"}, 32'(valid), 32'd0);
      check({name, "_done"}, 32'(frame_done), 32'd0);
      check({name, "_len"}, 32'(frame_len), 32'd0);
      check({name, "_err"}, 32'(err_code), 32'd0);
      check({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   int         base_v;
   int         base_e;
   int         nb;
   int         r;
   logic [7:0] b;
   bit         ok;

   initial begin
      line = 1'b1; err_clr = 1'b0; rst_n = 1'b0;
      tick(4);
      check_reset("por");
      rst_n = 1'b1;
      tick(2 * BIT);

      // basic frame 02 41 42 0D
      base_v = n_valid;
      send_byte(8'h02, 1); send_byte(8'h41, 1); send_byte(8'h42, 1); send_byte(8'h0D, 1);
      drain("basic");
      check("basic_valids", 32'(n_valid - base_v), 32'd2);
      check("basic_last_dout", 32'(last_dout), 32'h42);
      check("basic_len", 32'(last_len), 32'd2);
      check("basic_err", 32'(err_code), 32'd0);

      // framing error inside a frame, then clear
      base_v = n_valid;
      send_byte(8'h02, 1); send_byte(8'h41, 0);
      drain("ferr");
      check("ferr_err", 32'(err_code), 32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      check("ferr_valids", 32'(n_valid - base_v), 32'd0);
      pulse_clr();
      drain("ferr_clr");
      check("ferr_clr_err", 32'(err_code), 32'd0);

      // overflow: 33 payload bytes
      base_v = n_valid;
      send_byte(8'h02, 1);
      for (int i = 0; i < 33; i++) send_byte(8'h55, 1);
      drain("ovf");
      check("ovf_valids", 32'(n_valid - base_v), 32'd32);
      check("ovf_err", 32'(err_code), 32'd2);
      check("ovf_busy", 32'(busy), 32'd0);
      pulse_clr();
      drain("ovf_clr");

      // short low glitch on an idle line
      base_e = n_events;
      line = 1'b0; tick(10); line = 1'b1;
      tick(3 * BIT);
      check("glitch_events", 32'(n_events - base_e), 32'd0);
      check("glitch_busy", 32'(busy), 32'd0);

      // long idle inside a frame
      send_byte(8'h02, 1); send_byte(8'h41, 1);
      idle_bits(45);
      drain("idle");
`ifdef HV_RX_TIMEOUT_EN
      check("timeout_err", 32'(err_code), 32'd3);
      check("timeout_busy", 32'(busy), 32'd0);
      pulse_clr();
      drain("timeout_clr");
`else
      check("no_timeout_busy", 32'(busy), 32'd1);
      check("no_timeout_err", 32'(err_code), 32'd0);
      send_byte(8'h0D, 1);
      drain("no_timeout_close");
      check("no_timeout_len", 32'(last_len), 32'd1);
`endif

      // randomized frames
      for (int f = 0; f < 10; f++) begin
         nb = $urandom_range(1, 8);
         if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1);
         send_byte(8'h02, 1);
         for (int k = 0; k < nb; k++) begin
            r  = $urandom_range(0, 15);
            b  = (r == 0) ? 8'h02 : ((r == 1) ? 8'h0D : 8'($urandom));
            ok = ($urandom_range(0, 24) != 0);
            idle_bits($urandom_range(0, 2));
            send_byte(b, ok);
         end
         if ($urandom_range(0, 1) == 1) send_byte(8'h0D, 1);
         drain("rnd");
         if (m_st == 2) begin
            pulse_clr();
            drain("rnd_clr");
         end
      end
      if (m_st == 1) send_byte(8'h0D, 1);
      drain("rnd_end");

      // reset in the middle of a byte inside a frame
      send_byte(8'h02, 1);
      drain("mid_stx");
      line = 1'b0; tick(BIT);
      line = 1'b1; tick(BIT);
      line = 1'b0; tick(BIT / 2);
      rst_n = 1'b0;
      line  = 1'b1;
      exp_q.delete();
      m_st = 0; m_cnt = 0;
      tick(3);
      check_reset("mid_rst");
      rst_n = 1'b1;
      tick(2 * BIT);
      send_byte(8'h02, 1); send_byte(8'h43, 1); send_byte(8'h0D, 1);
      drain("after_rst");
      check("after_rst_dout", 32'(last_dout), 32'h43);
      check("after_rst_len", 32'(last_len), 32'd1);
      check("after_rst_busy", 32'(busy), 32'd0);

      tick(4);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
